switch_debounce: RTL and testbench

Synchronises and debounces the four raw board switches (sw1..sw4) so that the 2-bit LED adder sees clean, glitch-free operands. Each switch has a two-flop synchroniser and a saturating stability counter; a level is accepted only after it has been held for DEBOUNCE_CYCLES consecutive clocks. The block also emits one-cycle change strobes and presents the debounced levels pre-packed as the adder's two operands.

---
 rtl/switch_debounce.sv | 90 +++++++++
 tb/tb_switch_debounce.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Purpose: synchronise and debounce four raw switches and pack them as two 2-bit adder operands.
// Latency: DEBOUNCE_CYCLES+2 clock edges from the first edge that samples a new raw level to *_db/strobe.
// Backpressure: none; free-running per clock, strobes are single-cycle and never held.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   sw1..sw4              raw asynchronous bouncing switch levels (1 = pressed)
//   sw1_db..sw4_db        debounced stable levels
//   press[3:0]            one-cycle strobe on accepted 0->1 change, bit 0 = sw1
//   release_stb[3:0]      one-cycle strobe on accepted 1->0 change, bit 0 = sw1
//   changed               one-cycle strobe, OR of all press/release bits
//   op_a, op_b            {sw2_db, sw1_db} and {sw4_db, sw3_db}
module switch_debounce #(
  parameter  int DEBOUNCE_CYCLES = 250000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       sw4,
  output logic       sw1_db,
  output logic       sw2_db,
  output logic       sw3_db,
  output logic       sw4_db,
  output logic [3:0] press,
  output logic [3:0] release_stb,
  output logic       changed,
  output logic [1:0] op_a,
  output logic [1:0] op_b
);

  // Terminal count: the level must be seen on DEBOUNCE_CYCLES consecutive edges
  // (cnt 0..CNT_MAX plus the accepting edge itself).
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       press_q;
  logic [3:0]       release_q;
  logic [CNT_W-1:0] cnt [4];

  assign raw = {sw4, sw3, sw2, sw1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          // Any return to the accepted level discards the partial count.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i]    <= sync2[i];
          cnt[i]       <= '0;
          press_q[i]   <= sync2[i];
          release_q[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // All outputs come straight from registers: no raw-input-to-output path.
  assign sw1_db      = stable[0];
  assign sw2_db      = stable[1];
  assign sw3_db      = stable[2];
  assign sw4_db      = stable[3];
  assign press       = press_q;
  assign release_stb = release_q;
  assign changed     = |(press_q | release_q);
  assign op_a        = stable[1:0];
  assign op_b        = stable[3:2];

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;

  logic       clk;
  logic       rst_n;
  logic       sw1, sw2, sw3, sw4;
  logic       sw1_db, sw2_db, sw3_db, sw4_db;
  logic [3:0] press;
  logic [3:0] release_stb;
  logic       changed;
  logic [1:0] op_a;
  logic [1:0] op_b;

  int n_checks = 0;
  int n_fail   = 0;

  switch_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw1         (sw1),
    .sw2         (sw2),
    .sw3         (sw3),
    .sw4         (sw4),
    .sw1_db      (sw1_db),
    .sw2_db      (sw2_db),
    .sw3_db      (sw3_db),
    .sw4_db      (sw4_db),
    .press       (press),
    .release_stb (release_stb),
    .changed     (changed),
    .op_a        (op_a),
    .op_b        (op_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One record per clock: inputs driven before the edge, outputs expected after it.
  typedef struct {
    logic       rst_n;
    logic [3:0] sw;   // {sw4, sw3, sw2, sw1}
    logic [3:0] db;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       ch;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];

  task automatic add_row(input logic r, input logic [3:0] s, input logic [3:0] d,
                         input logic [3:0] p, input logic [3:0] l, input logic c);
    vec_t v;
    v.rst_n = r; v.sw = s; v.db = d; v.pr = p; v.rl = l; v.ch = c;
    vecs.push_back(v);
  endtask

  task automatic quiet(input int n, input logic r, input logic [3:0] s, input logic [3:0] d);
    for (int i = 0; i < n; i++) add_row(r, s, d, 4'h0, 4'h0, 1'b0);
  endtask

  function automatic logic [16:0] pack_exp(input logic [3:0] d, input logic [3:0] p,
                                           input logic [3:0] l, input logic c);
    return {d, p, l, c, d[1:0], d[3:2]};
  endfunction

  function automatic logic [16:0] pack_dut();
    return {sw4_db, sw3_db, sw2_db, sw1_db, press, release_stb, changed, op_a, op_b};
  endfunction

  task automatic drive_sw(input logic [3:0] s);
    sw1 = s[0]; sw2 = s[1]; sw3 = s[2]; sw4 = s[3];
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got db/pr/rl/ch/opa/opb=%b required %b", name, act, req);
    end
  endtask

  initial begin
    logic [16:0] e;
    int          n;
    bit          seen;

    rst_n = 1'b0;
    drive_sw(4'hF);

    // Reset with all switches held high, then acceptance of all four.
    quiet(3, 1'b0, 4'hF, 4'h0);
    quiet(5, 1'b1, 4'hF, 4'h0);
    add_row(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1);
    quiet(1, 1'b1, 4'hF, 4'hF);
    // Release sw2/sw3 so the later simultaneous release leaves both operands at 0.
    quiet(5, 1'b1, 4'h9, 4'hF);
    add_row(1'b1, 4'h9, 4'h9, 4'h0, 4'h6, 1'b1);
    quiet(1, 1'b1, 4'h9, 4'h9);
    // Simultaneous release of sw1 and sw4.
    quiet(5, 1'b1, 4'h0, 4'h9);
    add_row(1'b1, 4'h0, 4'h0, 4'h0, 4'h9, 1'b1);
    quiet(1, 1'b1, 4'h0, 4'h0);
    // Clean press of sw1.
    quiet(5, 1'b1, 4'h1, 4'h0);
    add_row(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
    quiet(1, 1'b1, 4'h1, 4'h1);
    // sw3 bounces 1,0,1,0 every two clocks, then holds high.
    quiet(2, 1'b1, 4'h5, 4'h1);
    quiet(2, 1'b1, 4'h1, 4'h1);
    quiet(2, 1'b1, 4'h5, 4'h1);
    quiet(2, 1'b1, 4'h1, 4'h1);
    quiet(5, 1'b1, 4'h5, 4'h1);
    add_row(1'b1, 4'h5, 4'h5, 4'h4, 4'h0, 1'b1);
    quiet(1, 1'b1, 4'h5, 4'h5);
    // sw2 glitch of three clocks is rejected.
    quiet(3, 1'b1, 4'h7, 4'h5);
    quiet(6, 1'b1, 4'h5, 4'h5);
    // sw2 rises, reset lands with cnt = 2, then a full count restarts.
    quiet(4, 1'b1, 4'h7, 4'h5);
    quiet(1, 1'b0, 4'h7, 4'h0);
    quiet(5, 1'b1, 4'h7, 4'h0);
    add_row(1'b1, 4'h7, 4'h7, 4'h7, 4'h0, 1'b1);
    quiet(2, 1'b1, 4'h7, 4'h7);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      drive_sw(vecs[i].sw);
      exp_q.push_back(pack_exp(vecs[i].db, vecs[i].pr, vecs[i].rl, vecs[i].ch));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("row%0d", i), pack_dut(), e);
    end

    // Asynchronous reset clears outputs without waiting for an edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", pack_dut(), 17'h0);
    @(negedge clk);
    drive_sw(4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_quiet%0d", i), pack_dut(), 17'h0);
    end

    // Latency of a clean sw4 press: strobe seen after the 6th edge.
    @(negedge clk);
    drive_sw(4'h8);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (changed === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL sw4_press_timeout: no strobe within %0d edges, required 6", n);
    end else begin
      n_checks++;
      if (n != 6) begin
        n_fail++;
        $display("FAIL sw4_latency: got %0d edges required 6", n);
      end
      check("sw4_press", pack_dut(), pack_exp(4'h8, 4'h8, 4'h0, 1'b1));
      @(posedge clk);
      #1;
      check("sw4_after", pack_dut(), pack_exp(4'h8, 4'h0, 4'h0, 1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
